// File: rtl/i2c_master_byte_pkg.sv
// Shared types and constants for the single-byte I2C master: state and phase encodings,
// and the SCL/SDA line decode for each state/phase.
package i2c_master_byte_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned BIT_W   = 3;

  localparam logic [PHASE_W-1:0] P0 = 2'd0;
  localparam logic [PHASE_W-1:0] P1 = 2'd1;
  localparam logic [PHASE_W-1:0] P2 = 2'd2;
  localparam logic [PHASE_W-1:0] P3 = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WRITE,
    ST_WRITE_ACK, ST_READ, ST_READ_ACK, ST_STOP
  } state_e;

  typedef struct packed {
    logic scl;
    logic sda_oe;
  } lines_t;

  // SCL is high in P1/P2 of every bit; only START/STOP move SDA while SCL is high.
  function automatic lines_t bus_lines(input state_e st, input logic [PHASE_W-1:0] ph,
                                       input logic tx_bit);
    lines_t l;
    l.scl    = (ph == P1) || (ph == P2);
    l.sda_oe = 1'b0;
    case (st)
      ST_IDLE:  l.scl = 1'b1;
      ST_START: begin
        l.scl    = (ph != P3);
        l.sda_oe = (ph == P2) || (ph == P3);
      end
      ST_ADDR, ST_WRITE: l.sda_oe = ~tx_bit;
      ST_STOP: begin
        l.scl    = (ph != P0);
        l.sda_oe = (ph != P3);
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/i2c_master_byte_if.sv
// Request/response and bus-line bundle between user logic and the I2C byte master.
interface i2c_master_byte_if;
  import i2c_master_byte_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] wdata;
  logic              sda_in;
  logic              scl;
  logic              sda_oe;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              ack_err;

  modport master (input start, addr, rw, wdata, sda_in,
                  output scl, sda_oe, busy, done, rdata, ack_err);
  modport slave  (output start, addr, rw, wdata, sda_in,
                  input scl, sda_oe, busy, done, rdata, ack_err);
endinterface

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Four i2c_clk cycles per bus bit; outputs are registered from the next state/phase.
module i2c_master_byte
  import i2c_master_byte_pkg::*;
(
  input  logic i2c_clk,
  input  logic rst,
  i2c_master_byte_if.master bus
);

  state_e              state_q,   state_d;
  logic [PHASE_W-1:0]  phase_q,   phase_d;
  logic [BIT_W-1:0]    bit_q,     bit_d;
  logic [DATA_W-1:0]   shreg_q,   shreg_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic                rw_q,      rw_d;
  logic                nack_q,    nack_d;
  logic                scl_q,     scl_d;
  logic                sda_oe_q,  sda_oe_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic                ack_err_q, ack_err_d;
  logic                last_c;
  lines_t              lines_c;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 2'd1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    last_c    = (phase_q == P3);

    case (state_q)
      ST_IDLE: begin
        phase_d = P0;
        if (bus.start) begin
          state_d   = ST_START;
          shreg_d   = {bus.addr, bus.rw};
          rw_d      = bus.rw;
          wdata_d   = bus.wdata;
          rdata_d   = '0;
          ack_err_d = 1'b0;
          nack_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: if (last_c) begin
        state_d = ST_ADDR;
        bit_d   = 3'd7;
      end
      ST_ADDR, ST_WRITE: if (last_c) begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (bit_q == 3'd0) state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
        else               bit_d   = bit_q - 3'd1;
      end
      ST_ADDR_ACK: begin
        if (phase_q == P2) nack_d = bus.sda_in;
        if (last_c) begin
          bit_d = 3'd7;
          if (nack_q)    state_d = ST_STOP;
          else if (rw_q) state_d = ST_READ;
          else begin
            state_d = ST_WRITE;
            shreg_d = wdata_q;
          end
        end
      end
      ST_WRITE_ACK: begin
        if (phase_q == P2) nack_d = bus.sda_in;
        if (last_c) state_d = ST_STOP;
      end
      ST_READ: begin
        if (phase_q == P2) shreg_d = {shreg_q[DATA_W-2:0], bus.sda_in};
        if (last_c) begin
          if (bit_q == 3'd0) begin
            state_d = ST_READ_ACK;
            rdata_d = shreg_q;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_READ_ACK: if (last_c) state_d = ST_STOP;
      ST_STOP: if (last_c) begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        ack_err_d = nack_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Lines follow the state/phase being entered so they stay aligned with it.
    lines_c  = bus_lines(state_d, phase_d, shreg_d[DATA_W-1]);
    scl_d    = lines_c.scl;
    sda_oe_d = lines_c.sda_oe;
  end

  always_ff @(posedge i2c_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= P0;
      bit_q     <= '0;
      shreg_q   <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.scl     = scl_q;
  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte: a transaction table driven against a simple
// slave model, plus reset-abort and start-held sequences.
module tb_i2c_master_byte;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  i2c_master_byte_if bus ();

  i2c_master_byte dut (
    .i2c_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       sl_ack_addr;
    logic       sl_ack_data;
    logic [7:0] sl_rdata;
    logic       poke_start;
    int         exp_len;
    logic       exp_ack_err;
    logic [7:0] exp_rdata;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Runs one transaction from IDLE; bench sits at posedge+1 on entry and exit.
  task automatic run_vec(input vec_t v, input bit hold_start);
    int         falls, rises, busy_cnt, done_at, b;
    int         nstart, nstop, start_c, stop_c;
    logic       prev_scl, prev_line, line, pull;
    logic [7:0] got_rdata, b0, b1;
    logic       got_err;
    logic [0:19] bits;
    falls = 0; rises = 0; busy_cnt = 0; done_at = 0;
    nstart = 0; nstop = 0; start_c = 0; stop_c = 0;
    prev_scl = 1'b1; prev_line = 1'b1;
    got_rdata = 8'h00; got_err = 1'b0; bits = '1;

    bus.addr = v.addr; bus.rw = v.rw; bus.wdata = v.wdata;
    bus.sda_in = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;

    for (int c = 1; c <= 120 && done_at == 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (prev_scl && !bus.scl) falls++;
      b    = falls - 1;
      pull = 1'b0;
      if (v.sl_ack_addr) begin
        if (b == 8) pull = 1'b1;
        else if (v.rw && b >= 9 && b <= 16) pull = ~v.sl_rdata[16-b];
        else if (!v.rw && b == 17) pull = v.sl_ack_data;
      end
      line = ~(bus.sda_oe | pull);
      bus.sda_in = line;
      if (prev_scl && bus.scl && line != prev_line) begin
        if (!line) begin nstart++; start_c = c; end
        else       begin nstop++;  stop_c  = c; end
      end
      if (!prev_scl && bus.scl) begin
        if (rises < 20) bits[rises] = line;
        rises++;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at   = c;
        got_rdata = bus.rdata;
        got_err   = bus.ack_err;
      end
      if (!hold_start) bus.start = v.poke_start && (c == 10 || c == 41 || c == 79);
      prev_scl  = bus.scl;
      prev_line = line;
    end

    b0 = 8'h00; b1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b0 = {b0[6:0], bits[i]};
      b1 = {b1[6:0], bits[i+9]};
    end
    check("busy_len", busy_cnt, v.exp_len);
    check("done_cycle", done_at, v.exp_len + 1);
    check("ack_err", int'(got_err), int'(v.exp_ack_err));
    check("rdata", int'(got_rdata), int'(v.exp_rdata));
    check("addr_byte", int'(b0), int'(v.exp_b0));
    if (v.exp_len == 80) check("data_byte", int'(b1), int'(v.exp_b1));
    if (v.rw && v.exp_len == 80) check("master_nack", int'(bits[17]), 1);
    check("start_events", nstart, 1);
    check("start_cycle", start_c, 3);
    check("stop_events", nstop, 1);
    check("stop_cycle", stop_c, v.exp_len);

    @(posedge clk); #1;
    if (hold_start) begin
      check("reaccept_busy", int'(bus.busy), 1);
      check("reaccept_scl", int'(bus.scl), 1);
      check("reaccept_sda_oe", int'(bus.sda_oe), 0);
      bus.start = 1'b0;
    end else begin
      check("done_width", int'(bus.done), 0);
      check("idle_busy", int'(bus.busy), 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_scl"}, int'(bus.scl), 1);
    check({tag, "_sda_oe"}, int'(bus.sda_oe), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_rdata"}, int'(bus.rdata), 0);
    check({tag, "_ack_err"}, int'(bus.ack_err), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           addr   rw    wdata  ackA  ackD  srd    poke  len ae    rdata  b0     b1
    vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 80, 1'b0, 8'h00, 8'hA0, 8'hA5};
    vecs[1] = '{7'h50, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 80, 1'b0, 8'h3C, 8'hA1, 8'h3C};
    vecs[2] = '{7'h50, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 44, 1'b1, 8'h00, 8'hA0, 8'h00};
    vecs[3] = '{7'h2D, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 80, 1'b1, 8'h00, 8'h5A, 8'h81};
    vecs[4] = '{7'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 80, 1'b0, 8'hC3, 8'hFF, 8'hC3};
    vecs[5] = '{7'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 80, 1'b0, 8'h00, 8'h00, 8'hFF};

    rst = 1'b1;
    bus.start = 1'b0; bus.addr = '0; bus.rw = 1'b0; bus.wdata = '0; bus.sda_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

    // Abort a write partway through: reset must return the lines to idle with no STOP.
    bus.addr = 7'h50; bus.rw = 1'b0; bus.wdata = 8'hA5; bus.sda_in = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 20; c++) begin @(posedge clk); #1; end
    check("midrun_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0], 1'b0);

    // start held through done: re-accepted in the done cycle.
    run_vec(vecs[1], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
